// File: rtl/cog_segment_accumulator.sv
// cog_segment_accumulator
//   Accumulates per-segment pixel count, sum(i) and sum(i*x) from the CoG
//   receiver stream. Each segment of at least MIN_LEN pixels produces one
//   record in a small output FIFO; every frame ends with an EOF marker record.
//   Optional feature macro: COG_PEAK_EN (per-record peak intensity output).
module cog_segment_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int X_WIDTH    = 11,
   parameter int SUM_WIDTH  = 20,
   parameter int MOM_WIDTH  = 32,
   parameter int MIN_LEN    = 3,
   parameter int FIFO_DEPTH = 4   // power of 2, at least 2
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_aresetn,
   input  logic [DATA_WIDTH-1:0] i_data_image,
   input  logic                  i_data_valid,
   input  logic [X_WIDTH-1:0]    i_start_point,
   input  logic                  i_start_of_fig,
   input  logic                  i_end_of_fig,
   input  logic                  i_end_of_line,
   input  logic                  i_end_of_frame,
   input  logic                  i_new_frame,
   output logic                  m_rec_valid,
   input  logic                  m_rec_ready,
   output logic                  m_rec_eof,
   output logic [X_WIDTH-1:0]    m_rec_line,
   output logic [X_WIDTH-1:0]    m_rec_start,
   output logic [X_WIDTH-1:0]    m_rec_len,
   output logic [SUM_WIDTH-1:0]  m_rec_sum_i,
   output logic [MOM_WIDTH-1:0]  m_rec_sum_ix,
`ifdef COG_PEAK_EN
   output logic [DATA_WIDTH-1:0] m_rec_peak,
`endif
   output logic                  o_overflow,
   output logic                  o_seq_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = DATA_WIDTH + X_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT_FIG, ACCUM} state_t;

   typedef struct packed {
      logic                 eof;
      logic [X_WIDTH-1:0]   line;
      logic [X_WIDTH-1:0]   start;
      logic [X_WIDTH-1:0]   len;
      logic [SUM_WIDTH-1:0] sum_i;
      logic [MOM_WIDTH-1:0] sum_ix;
`ifdef COG_PEAK_EN
      logic [DATA_WIDTH-1:0] peak;
`endif
   } rec_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t               r_state, w_state_n;
   logic [X_WIDTH-1:0]   r_start, w_start_n;
   logic [X_WIDTH-1:0]   r_len, w_len_n;
   logic [SUM_WIDTH-1:0] r_sum, w_sum_n;
   logic [MOM_WIDTH-1:0] r_mom, w_mom_n;
`ifdef COG_PEAK_EN
   logic [DATA_WIDTH-1:0] r_peak, w_peak_n;
`endif
   logic [X_WIDTH-1:0]   r_line, w_line_n;
   logic                 r_eof_pend, w_eof_pend_n;
   logic [X_WIDTH-1:0]   r_eof_pend_line;
   logic                 r_overflow, r_seq_err;

   rec_t                 r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr, r_rd;
   logic [AW:0]          r_cnt;

   // Per-cycle decode
   logic                 w_start_seg, w_pix_acc, w_done, w_push_rec, w_eof_now;
   logic [X_WIDTH-1:0]   w_x;
   logic [PW-1:0]        w_prod;
   logic                 w_push, w_pop, w_full, w_wr_en;
   rec_t                 w_push_data, w_head;

   // A new segment may open in WAIT_FIG or (with a sequence error) in ACCUM
   assign w_start_seg = (r_state != IDLE) & i_start_of_fig & i_data_valid;
   assign w_pix_acc   = (r_state == ACCUM) & i_data_valid & ~w_start_seg;

   // Column of the current pixel: new start, or start + pixels already seen
   assign w_x    = w_start_seg ? i_start_point : (r_start + r_len);
   assign w_prod = {{X_WIDTH{1'b0}}, i_data_image} * {{DATA_WIDTH{1'b0}}, w_x};

   // Next segment accumulator values including this cycle's pixel
   always_comb begin
      w_start_n = r_start;
      w_len_n   = r_len;
      w_sum_n   = r_sum;
      w_mom_n   = r_mom;
`ifdef COG_PEAK_EN
      w_peak_n  = r_peak;
`endif
      if (w_start_seg) begin
         w_start_n = i_start_point;
         w_len_n   = X_WIDTH'(1);
         w_sum_n   = SUM_WIDTH'(i_data_image);
         w_mom_n   = MOM_WIDTH'(w_prod);
`ifdef COG_PEAK_EN
         w_peak_n  = i_data_image;
`endif
      end else if (w_pix_acc) begin
         w_len_n   = (r_len == '1) ? r_len : r_len + 1'b1;
         w_sum_n   = r_sum + SUM_WIDTH'(i_data_image);
         w_mom_n   = r_mom + MOM_WIDTH'(w_prod);
`ifdef COG_PEAK_EN
         w_peak_n  = (i_data_image > r_peak) ? i_data_image : r_peak;
`endif
      end
   end

   // Segment completion and push decisions; new_frame abandons the segment
   assign w_done     = ~i_new_frame & i_end_of_fig & (w_start_seg | (r_state == ACCUM));
   assign w_push_rec = w_done & (w_len_n >= X_WIDTH'(MIN_LEN));
   assign w_eof_now  = i_end_of_frame & ~i_new_frame;

   // Line counter: records take the value before any coincident increment
   assign w_line_n = i_new_frame   ? '0 :
                     i_end_of_line ? r_line + 1'b1 : r_line;

   // A marker colliding with a record (or another marker) waits one cycle
   assign w_eof_pend_n = w_eof_now & (w_push_rec | r_eof_pend);

   // Next-state logic
   always_comb begin
      w_state_n = r_state;
      if (i_new_frame) begin
         w_state_n = WAIT_FIG;
      end else if (i_end_of_frame) begin
         w_state_n = IDLE;
      end else begin
         case (r_state)
            WAIT_FIG: if (w_start_seg & ~i_end_of_fig) w_state_n = ACCUM;
            ACCUM:    if (i_end_of_fig)                w_state_n = WAIT_FIG;
            default:  w_state_n = r_state;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) r_state <= IDLE;
      else                r_state <= w_state_n;
   end

   // Segment accumulators, cleared when a frame restarts
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         r_start <= '0;
         r_len   <= '0;
         r_sum   <= '0;
         r_mom   <= '0;
`ifdef COG_PEAK_EN
         r_peak  <= '0;
`endif
      end else if (i_new_frame) begin
         r_start <= '0;
         r_len   <= '0;
         r_sum   <= '0;
         r_mom   <= '0;
`ifdef COG_PEAK_EN
         r_peak  <= '0;
`endif
      end else begin
         r_start <= w_start_n;
         r_len   <= w_len_n;
         r_sum   <= w_sum_n;
         r_mom   <= w_mom_n;
`ifdef COG_PEAK_EN
         r_peak  <= w_peak_n;
`endif
      end
   end

   // Line index, pending EOF marker and sticky status flags
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         r_line          <= '0;
         r_eof_pend      <= 1'b0;
         r_eof_pend_line <= '0;
         r_overflow      <= 1'b0;
         r_seq_err       <= 1'b0;
      end else begin
         r_line          <= w_line_n;
         r_eof_pend      <= w_eof_pend_n;
         r_eof_pend_line <= w_line_n;
         if (i_new_frame)                                   r_overflow <= 1'b0;
         else if (w_push & w_full & ~w_pop)                 r_overflow <= 1'b1;
         if (i_new_frame)                                   r_seq_err  <= 1'b0;
         else if ((r_state == ACCUM) & i_start_of_fig)      r_seq_err  <= 1'b1;
      end
   end

   // Push source select: pending marker, then segment record, then marker
   always_comb begin
      w_push      = 1'b0;
      w_push_data = '0;
      if (r_eof_pend) begin
         w_push           = 1'b1;
         w_push_data.eof  = 1'b1;
         w_push_data.line = r_eof_pend_line;
      end else if (w_push_rec) begin
         w_push             = 1'b1;
         w_push_data.line   = r_line;
         w_push_data.start  = w_start_n;
         w_push_data.len    = w_len_n;
         w_push_data.sum_i  = w_sum_n;
         w_push_data.sum_ix = w_mom_n;
`ifdef COG_PEAK_EN
         w_push_data.peak   = w_peak_n;
`endif
      end else if (w_eof_now) begin
         w_push           = 1'b1;
         w_push_data.eof  = 1'b1;
         w_push_data.line = r_line;
      end
   end

   // FIFO control: a pop frees room for a same-cycle push when full
   assign w_pop   = (r_cnt != '0) & m_rec_ready;
   assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
   assign w_wr_en = w_push & (~w_full | w_pop);

   // FIFO storage and pointers
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr] <= w_push_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Head entry drives the record interface directly
   assign w_head       = r_mem[r_rd];
   assign m_rec_valid  = (r_cnt != '0);
   assign m_rec_eof    = w_head.eof;
   assign m_rec_line   = w_head.line;
   assign m_rec_start  = w_head.start;
   assign m_rec_len    = w_head.len;
   assign m_rec_sum_i  = w_head.sum_i;
   assign m_rec_sum_ix = w_head.sum_ix;
`ifdef COG_PEAK_EN
   assign m_rec_peak   = w_head.peak;
`endif
   assign o_overflow   = r_overflow;
   assign o_seq_error  = r_seq_err;

endmodule

// File: tb/tb_cog_segment_accumulator.sv
// Directed bench for cog_segment_accumulator (default parameters).
module tb_cog_segment_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data = '0;
   logic        dvld = 1'b0;
   logic [10:0] spt = '0;
   logic        sof = 1'b0, efig = 1'b0, eol = 1'b0, eofr = 1'b0, nf = 1'b0;
   logic        rdy = 1'b0;
   logic        rvld, reof, ovf, serr;
   logic [10:0] rline, rstart, rlen;
   logic [19:0] rsum;
   logic [31:0] rmom;
`ifdef COG_PEAK_EN
   logic [7:0]  rpeak;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cog_segment_accumulator dut (
      .i_sys_clk(clk), .i_sys_aresetn(rst_n),
      .i_data_image(data), .i_data_valid(dvld), .i_start_point(spt),
      .i_start_of_fig(sof), .i_end_of_fig(efig), .i_end_of_line(eol),
      .i_end_of_frame(eofr), .i_new_frame(nf),
      .m_rec_valid(rvld), .m_rec_ready(rdy), .m_rec_eof(reof),
      .m_rec_line(rline), .m_rec_start(rstart), .m_rec_len(rlen),
      .m_rec_sum_i(rsum), .m_rec_sum_ix(rmom),
`ifdef COG_PEAK_EN
      .m_rec_peak(rpeak),
`endif
      .o_overflow(ovf), .o_seq_error(serr)
   );

   // One clock of stimulus; inputs return to zero 1ns after the edge
   task automatic px(input logic [7:0] d, input logic v, input logic s, input logic ef,
                     input logic el, input logic eo, input logic n, input logic [10:0] sp);
      data = d; dvld = v; sof = s; efig = ef; eol = el; eofr = eo; nf = n; spt = sp;
      @(posedge clk); #1;
      data = '0; dvld = 0; sof = 0; efig = 0; eol = 0; eofr = 0; nf = 0; spt = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rvld); end
      checks++; if (rlen !== 11'd0) begin errors++; $display("FAIL reset_len got %0d want 0", rlen); end
      checks++; if (ovf !== 1'b0 || serr !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0b serr=%0b want 0 0", ovf, serr); end
   endtask

   task automatic test_basic;
      rdy = 1;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      px(5, 1, 1, 0, 0, 0, 0, 10);
      px(10, 1, 0, 0, 0, 0, 0, 0);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL basic_early got valid=%0b want 0", rvld); end
      px(20, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (rvld !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", rvld); end
      checks++; if ({reof, rline, rstart, rlen} !== {1'b0, 11'd0, 11'd10, 11'd3})
         begin errors++; $display("FAIL basic_hdr got eof=%0b line=%0d start=%0d len=%0d want 0 0 10 3", reof, rline, rstart, rlen); end
      checks++; if (rsum !== 20'd35) begin errors++; $display("FAIL basic_sum got %0d want 35", rsum); end
      checks++; if (rmom !== 32'd400) begin errors++; $display("FAIL basic_mom got %0d want 400", rmom); end
      idle(1);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL basic_pop got valid=%0b want 0", rvld); end
   endtask

   task automatic test_short_and_eof;
      rdy = 0;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      px(100, 1, 1, 0, 0, 0, 0, 50);
      px(100, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL short_drop got valid=%0b want 0", rvld); end
      px(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if ({rvld, reof, rline, rlen, rsum} !== {1'b1, 1'b1, 11'd0, 11'd0, 20'd0})
         begin errors++; $display("FAIL eof_marker got v=%0b eof=%0b line=%0d len=%0d sum=%0d want 1 1 0 0 0", rvld, reof, rline, rlen, rsum); end
      rdy = 1;
      idle(1);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL eof_single got valid=%0b want 0", rvld); end
   endtask

   task automatic test_lines;
      logic [10:0] el [4] = '{11'd0, 11'd0, 11'd1, 11'd2};
      logic [10:0] es [4] = '{11'd5, 11'd20, 11'd100, 11'd0};
      logic [19:0] eu [4] = '{20'd6, 20'd30, 20'd3, 20'd0};
      logic [31:0] em [4] = '{32'd38, 32'd630, 32'd303, 32'd0};
      logic        ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      rdy = 0;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      px(1, 1, 1, 0, 0, 0, 0, 5);  px(2, 1, 0, 0, 0, 0, 0, 0);  px(3, 1, 0, 1, 0, 0, 0, 0);
      px(10, 1, 1, 0, 0, 0, 0, 20); px(10, 1, 0, 0, 0, 0, 0, 0); px(10, 1, 0, 1, 0, 0, 0, 0);
      px(0, 0, 0, 0, 1, 0, 0, 0);
      px(1, 1, 1, 0, 0, 0, 0, 100); px(1, 1, 0, 0, 0, 0, 0, 0);
      px(1, 1, 0, 1, 1, 1, 0, 0);
      rdy = 1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rvld, reof, rline, rstart, rsum, rmom} !== {1'b1, ee[i], el[i], es[i], eu[i], em[i]})
            begin errors++; $display("FAIL lines_rec%0d got v=%0b eof=%0b line=%0d start=%0d sum=%0d mom=%0d want 1 %0b %0d %0d %0d %0d",
                                     i, rvld, reof, rline, rstart, rsum, rmom, ee[i], el[i], es[i], eu[i], em[i]); end
         idle(1);
      end
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL lines_end got valid=%0b want 0", rvld); end
   endtask

   task automatic test_overflow;
      rdy = 0;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         px(8'(k), 1, 1, 0, 0, 0, 0, 11'(k*10)); px(8'(k), 1, 0, 0, 0, 0, 0, 0); px(8'(k), 1, 0, 1, 0, 0, 0, 0);
      end
      checks++; if ({rvld, ovf} !== 2'b11) begin errors++; $display("FAIL ovf_set got v=%0b ovf=%0b want 1 1", rvld, ovf); end
      rdy = 1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rvld, rstart, rsum} !== {1'b1, 11'((i+1)*10), 20'(3*(i+1))})
            begin errors++; $display("FAIL ovf_drain%0d got v=%0b start=%0d sum=%0d want 1 %0d %0d", i, rvld, rstart, rsum, (i+1)*10, 3*(i+1)); end
         idle(1);
      end
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL ovf_empty got valid=%0b want 0", rvld); end
      px(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", ovf); end
      // Full FIFO with a pop on the same edge as a push: nothing lost
      rdy = 0;
      for (int k = 1; k <= 5; k++) begin
         px(8'(k), 1, 1, 0, 0, 0, 0, 11'(k*10)); px(8'(k), 1, 0, 0, 0, 0, 0, 0);
         if (k == 5) rdy = 1;
         px(8'(k), 1, 0, 1, 0, 0, 0, 0);
         rdy = 0;
      end
      checks++; if ({rvld, ovf} !== 2'b10) begin errors++; $display("FAIL pushpop_full got v=%0b ovf=%0b want 1 0", rvld, ovf); end
      rdy = 1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rvld, rstart} !== {1'b1, 11'((i+2)*10)})
            begin errors++; $display("FAIL pushpop_drain%0d got v=%0b start=%0d want 1 %0d", i, rvld, rstart, (i+2)*10); end
         idle(1);
      end
   endtask

   task automatic test_seq_error;
      rdy = 1;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (serr !== 1'b0) begin errors++; $display("FAIL seq_clear got %0b want 0", serr); end
      px(9, 1, 1, 0, 0, 0, 0, 30); px(9, 1, 0, 0, 0, 0, 0, 0);
      px(7, 1, 1, 0, 0, 0, 0, 40); px(7, 1, 0, 0, 0, 0, 0, 0); px(7, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (serr !== 1'b1) begin errors++; $display("FAIL seq_set got %0b want 1", serr); end
      checks++; if ({rvld, rstart, rlen, rsum, rmom} !== {1'b1, 11'd40, 11'd3, 20'd21, 32'd861})
         begin errors++; $display("FAIL seq_rec got v=%0b start=%0d len=%0d sum=%0d mom=%0d want 1 40 3 21 861", rvld, rstart, rlen, rsum, rmom); end
      idle(1);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL seq_only got valid=%0b want 0", rvld); end
   endtask

`ifdef COG_PEAK_EN
   task automatic test_peak;
      rdy = 1;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      px(3, 1, 1, 0, 0, 0, 0, 0); px(200, 1, 0, 0, 0, 0, 0, 0); px(7, 1, 0, 1, 0, 0, 0, 0);
      checks++; if ({rvld, rpeak, rsum} !== {1'b1, 8'd200, 20'd210})
         begin errors++; $display("FAIL peak got v=%0b peak=%0d sum=%0d want 1 200 210", rvld, rpeak, rsum); end
      idle(1);
   endtask
`endif

   task automatic test_reset_mid;
      rdy = 0;
      px(0, 0, 0, 0, 0, 0, 1, 0);
      px(1, 1, 1, 0, 0, 0, 0, 0); px(1, 1, 0, 0, 0, 0, 0, 0); px(1, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (rvld !== 1'b1) begin errors++; $display("FAIL rstmid_pre got valid=%0b want 1", rvld); end
      px(4, 1, 1, 0, 0, 0, 0, 5); px(4, 1, 0, 0, 0, 0, 0, 0);
      rst_n = 0;
      #1;
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", rvld); end
      @(posedge clk); #1;
      rst_n = 1;
      px(4, 1, 0, 0, 0, 0, 0, 0); px(4, 1, 0, 1, 0, 0, 0, 0);
      idle(1);
      checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL rstmid_norec got valid=%0b want 0", rvld); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1;
      idle(1);
      test_basic();
      test_short_and_eof();
      test_lines();
      test_overflow();
      test_seq_error();
`ifdef COG_PEAK_EN
      test_peak();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
